// File: rtl/led_cube_pkg.sv
// Package: led_cube_pkg
// Shared types and default widths for the LED cube animation path.
//  - anim_state_t : sequencer FSM state, encoding visible on state_dbg
//  - FRAME_AW_DEF : default frame index width
//  - ROW_AW       : row address width inside one frame
//                   (store address = {frame_idx, row_addr})
//  - TIMER_W_DEF  : default hold timer width
//  - FRAME_TICKS_DEF : default hold time in clocks (30 ms at 50 MHz)
package led_cube_pkg;

    localparam int unsigned FRAME_AW_DEF    = 8;
    localparam int unsigned ROW_AW          = 6;
    localparam int unsigned TIMER_W_DEF     = 21;
    localparam int unsigned FRAME_TICKS_DEF = 1500000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHOW    = 2'd2,
        ST_ADVANCE = 2'd3
    } anim_state_t;

endpackage : led_cube_pkg

// File: rtl/led_cube_anim_sequencer_frame_hold_timer.sv
// Module: frame_hold_timer
// Saturating up-counter measuring how long the current frame has been shown.
// Ports:
//  clk     in   system clock
//  rst     in   asynchronous active-high reset (count -> 0)
//  clear   in   synchronous clear to 0 (wins over enable)
//  enable  in   count up by one this clock (ignored once saturated)
//  expired out  count has reached MAX_COUNT
module frame_hold_timer #(
    parameter int unsigned        TIMER_W   = 21,
    parameter logic [TIMER_W-1:0] MAX_COUNT = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX_COUNT)) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = (count == MAX_COUNT);

endmodule : frame_hold_timer

// File: rtl/led_cube_anim_sequencer.sv
// Module: led_cube_anim_sequencer
// Frame-level scheduler for the LED cube animation path. Steps frame_idx
// through the animation store, holding each frame for FRAME_TICKS clocks,
// and only swaps frames on a layer-driver scan boundary (drv_done).
// Ports:
//  clk, rst     clock / asynchronous active-high reset
//  play         pulse: start playback from IDLE (needs num_frames != 0)
//  pause        level: freeze the hold timer while showing a frame
//  stop         pulse: abort to IDLE, highest priority
//  loop_en      1 = wrap after last frame, 0 = one-shot
//  num_frames   frame count, captured when play is accepted
//  drv_done     pulse from layer driver at end of each full scan
//  drv_start    pulse: driver (re)starts on current frame
//  drv_stop     pulse: driver halts
//  frame_idx    current frame index
//  busy         high in every state except IDLE
//  anim_done    pulse when a one-shot animation completes
//  state_dbg    encoded FSM state
module led_cube_anim_sequencer
    import led_cube_pkg::*;
#(
    parameter int unsigned        FRAME_AW    = FRAME_AW_DEF,
    parameter int unsigned        TIMER_W     = TIMER_W_DEF,
    parameter logic [TIMER_W-1:0] FRAME_TICKS = TIMER_W'(FRAME_TICKS_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                play,
    input  logic                pause,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [FRAME_AW-1:0] num_frames,
    input  logic                drv_done,
    output logic                drv_start,
    output logic                drv_stop,
    output logic [FRAME_AW-1:0] frame_idx,
    output logic                busy,
    output logic                anim_done,
    output logic [1:0]          state_dbg
);

    anim_state_t         state_q, state_nx;
    logic [FRAME_AW-1:0] frame_nx;
    logic [FRAME_AW-1:0] nframes_q, nframes_nx;
    logic                drv_stop_nx;
    logic                anim_done_nx;
    logic                timer_clear;
    logic                timer_en;
    logic                timer_expired;
    logic                last_frame;

    frame_hold_timer #(
        .TIMER_W   (TIMER_W),
        .MAX_COUNT (FRAME_TICKS - TIMER_W'(1))
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // Compare in FRAME_AW bits so num_frames=1 gives last index 0.
    assign last_frame = (frame_idx == (nframes_q - FRAME_AW'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            frame_idx <= '0;
            nframes_q <= '0;
            drv_stop  <= 1'b0;
            anim_done <= 1'b0;
        end else begin
            state_q   <= state_nx;
            frame_idx <= frame_nx;
            nframes_q <= nframes_nx;
            drv_stop  <= drv_stop_nx;
            anim_done <= anim_done_nx;
        end
    end

    always_comb begin
        state_nx     = state_q;
        frame_nx     = frame_idx;
        nframes_nx   = nframes_q;
        drv_stop_nx  = 1'b0;
        anim_done_nx = 1'b0;
        // Timer only runs in SHOW; everywhere else it is held at zero so
        // each SHOW starts from a fresh count.
        timer_clear  = (state_q != ST_SHOW);
        timer_en     = (state_q == ST_SHOW) && !pause;

        if (stop) begin
            state_nx    = ST_IDLE;
            frame_nx    = '0;
            drv_stop_nx = 1'b1;
            timer_clear = 1'b1;
            timer_en    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (play && (num_frames != '0)) begin
                        state_nx   = ST_LOAD;
                        nframes_nx = num_frames;
                        frame_nx   = '0;
                    end
                end
                ST_LOAD: begin
                    state_nx = ST_SHOW;
                end
                ST_SHOW: begin
                    // Swap only on a scan boundary after the hold time.
                    if (timer_expired && drv_done) begin
                        state_nx = ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    if (last_frame) begin
                        frame_nx = '0;
                        if (loop_en) begin
                            state_nx = ST_LOAD;
                        end else begin
                            state_nx     = ST_IDLE;
                            anim_done_nx = 1'b1;
                            drv_stop_nx  = 1'b1;
                        end
                    end else begin
                        frame_nx = frame_idx + FRAME_AW'(1);
                        state_nx = ST_LOAD;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // drv_start is decoded from LOAD; drv_stop/anim_done are registered and
    // only set on transitions into IDLE, so they never overlap drv_start.
    assign drv_start = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule : led_cube_anim_sequencer
